// File: rtl/stage_e_exec_pkg.sv
// Shared encodings for the execute stage: ALU ops, MDU ops, result/forward selects, latencies.
package stage_e_exec_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;
    localparam logic [2:0] MD_NONE7 = 3'd7;

    localparam logic [1:0] RD_ALU = 2'd0;
    localparam logic [1:0] RD_HI  = 2'd1;
    localparam logic [1:0] RD_LO  = 2'd2;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_M   = 2'd1;
    localparam logic [1:0] FWD_W   = 2'd2;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    // Two's-complement negate when neg is set; used to restore signs around an unsigned divider.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        if (neg) begin
            cond_neg = 32'h0000_0000 - v;
        end else begin
            cond_neg = v;
        end
    endfunction

endpackage

// File: rtl/stage_e_exec_md_unit.sv
// Multi-cycle multiply/divide unit: HI/LO registers, latency counter and operand latches.
module stage_e_exec_md_unit
    import stage_e_exec_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  md_op,
    input  logic        md_start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_busy
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    logic [31:0] hi_r, lo_r, a_r, b_r;
    logic [3:0]  cnt_r;
    logic [2:0]  op_r;
    logic        busy_r;

    logic [63:0] smul_s, umul_s;
    logic [31:0] a_mag_s, b_mag_s, sq_s, sr_s, uq_s, ur_s;
    logic [31:0] res_hi_s, res_lo_s;
    logic        b_nz_s;

    // Final result of the latched operation, written into HI/LO on the last counting edge.
    always_comb begin
        smul_s   = {{32{a_r[31]}}, a_r} * {{32{b_r[31]}}, b_r};
        umul_s   = {32'h0000_0000, a_r} * {32'h0000_0000, b_r};
        b_nz_s   = (b_r != 32'h0000_0000);
        a_mag_s  = cond_neg(a_r, a_r[31]);
        b_mag_s  = cond_neg(b_r, b_r[31]);
        sq_s     = 32'h0000_0000;
        sr_s     = 32'h0000_0000;
        uq_s     = 32'h0000_0000;
        ur_s     = 32'h0000_0000;
        res_hi_s = hi_r;
        res_lo_s = lo_r;
        // Magnitude divide keeps truncation toward zero; 0x80000000/-1 falls out as 0x80000000 rem 0.
        if (b_nz_s) begin
            sq_s = cond_neg(a_mag_s / b_mag_s, a_r[31] ^ b_r[31]);
            sr_s = cond_neg(a_mag_s % b_mag_s, a_r[31]);
            uq_s = a_r / b_r;
            ur_s = a_r % b_r;
        end else begin
            sq_s = 32'hFFFF_FFFF;
            sr_s = a_r;
            uq_s = 32'hFFFF_FFFF;
            ur_s = a_r;
        end
        case (op_r)
            MD_MULT:  {res_hi_s, res_lo_s} = smul_s;
            MD_MULTU: {res_hi_s, res_lo_s} = umul_s;
            MD_DIV:   begin res_hi_s = sr_s; res_lo_s = sq_s; end
            MD_DIVU:  begin res_hi_s = ur_s; res_lo_s = uq_s; end
            default:  begin res_hi_s = hi_r; res_lo_s = lo_r; end
        endcase
    end

    // Accept, count down, and commit; new requests are only looked at while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r   <= 32'h0000_0000;
            lo_r   <= 32'h0000_0000;
            a_r    <= 32'h0000_0000;
            b_r    <= 32'h0000_0000;
            cnt_r  <= 4'd0;
            op_r   <= MD_NONE;
            busy_r <= 1'b0;
        end else if (cnt_r > 4'd1) begin
            cnt_r <= cnt_r - 4'd1;
        end else if (cnt_r == 4'd1) begin
            hi_r   <= res_hi_s;
            lo_r   <= res_lo_s;
            cnt_r  <= 4'd0;
            busy_r <= 1'b0;
        end else if (md_start) begin
            case (md_op)
                MD_MTHI: hi_r <= a;
                MD_MTLO: lo_r <= a;
                MD_MULT, MD_MULTU: begin
                    a_r <= a; b_r <= b; op_r <= md_op;
                    cnt_r <= MULT_CNT; busy_r <= 1'b1;
                end
                MD_DIV, MD_DIVU: begin
                    a_r <= a; b_r <= b; op_r <= md_op;
                    cnt_r <= DIV_CNT; busy_r <= 1'b1;
                end
                default: op_r <= op_r;
            endcase
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign hi      = hi_r;
    assign lo      = lo_r;
    assign md_busy = busy_r;

endmodule

// File: rtl/stage_e_exec.sv
// Execute stage: operand forwarding, combinational ALU, result select and the MDU.
module stage_e_exec
    import stage_e_exec_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  alu_ctr,
    input  logic        alu_src,
    input  logic [31:0] data1_in,
    input  logic [31:0] data2_in,
    input  logic [31:0] imm_in,
    input  logic [1:0]  fwd_a_sel,
    input  logic [1:0]  fwd_b_sel,
    input  logic [31:0] fwd_m,
    input  logic [31:0] fwd_w,
    input  logic [2:0]  md_op,
    input  logic        md_start,
    input  logic [1:0]  md_rd_sel,
    output logic [31:0] result_out,
    output logic [31:0] wdata_out,
    output logic        md_busy
);

    logic [31:0] a_s, bf_s, b_s, alu_s, hi_s, lo_s;
    logic [4:0]  shamt_s;

    // Forwarding muxes; code 3 falls back to the ID/EX value.
    always_comb begin
        case (fwd_a_sel)
            FWD_M:   a_s = fwd_m;
            FWD_W:   a_s = fwd_w;
            default: a_s = data1_in;
        endcase
        case (fwd_b_sel)
            FWD_M:   bf_s = fwd_m;
            FWD_W:   bf_s = fwd_w;
            default: bf_s = data2_in;
        endcase
        if (alu_src) begin
            b_s = imm_in;
        end else begin
            b_s = bf_s;
        end
    end

    assign shamt_s = imm_in[10:6];

    // ALU: wrap-around arithmetic, shifts always act on B.
    always_comb begin
        case (alu_ctr)
            ALU_ADD:  alu_s = a_s + b_s;
            ALU_SUB:  alu_s = a_s - b_s;
            ALU_AND:  alu_s = a_s & b_s;
            ALU_OR:   alu_s = a_s | b_s;
            ALU_XOR:  alu_s = a_s ^ b_s;
            ALU_NOR:  alu_s = ~(a_s | b_s);
            ALU_SLT:  alu_s = {31'h0000_0000, ($signed(a_s) < $signed(b_s))};
            ALU_SLTU: alu_s = {31'h0000_0000, (a_s < b_s)};
            ALU_SLL:  alu_s = b_s << shamt_s;
            ALU_SRL:  alu_s = b_s >> shamt_s;
            ALU_SRA:  alu_s = $unsigned($signed(b_s) >>> shamt_s);
            ALU_LUI:  alu_s = {b_s[15:0], 16'h0000};
            default:  alu_s = 32'h0000_0000;
        endcase
    end

    // Result select between ALU and HI/LO.
    always_comb begin
        case (md_rd_sel)
            RD_ALU:  result_out = alu_s;
            RD_HI:   result_out = hi_s;
            RD_LO:   result_out = lo_s;
            default: result_out = 32'h0000_0000;
        endcase
    end

    assign wdata_out = bf_s;

    stage_e_exec_md_unit #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md (
        .clk      (clk),
        .rst      (rst),
        .md_op    (md_op),
        .md_start (md_start),
        .a        (a_s),
        .b        (bf_s),
        .hi       (hi_s),
        .lo       (lo_s),
        .md_busy  (md_busy)
    );

endmodule

// File: tb/tb_stage_e_exec.sv
// Bench for stage_e_exec: directed literal checks plus a randomized run against a behavioural model.
module tb_stage_e_exec;
    import stage_e_exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  alu_ctr;
    logic        alu_src;
    logic [31:0] data1_in, data2_in, imm_in, fwd_m, fwd_w;
    logic [1:0]  fwd_a_sel, fwd_b_sel, md_rd_sel;
    logic [2:0]  md_op;
    logic        md_start;
    logic [31:0] result_out, wdata_out;
    logic        md_busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Behavioural model: HI/LO, plus a pending result that lands LAT edges after acceptance.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    bit          m_pend;
    int          edges = 0;
    int          m_done;

    always #5 clk = ~clk;

    stage_e_exec dut (
        .clk(clk), .rst(rst), .alu_ctr(alu_ctr), .alu_src(alu_src),
        .data1_in(data1_in), .data2_in(data2_in), .imm_in(imm_in),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .fwd_m(fwd_m), .fwd_w(fwd_w),
        .md_op(md_op), .md_start(md_start), .md_rd_sel(md_rd_sel),
        .result_out(result_out), .wdata_out(wdata_out), .md_busy(md_busy)
    );

    function automatic logic [31:0] f_fwd(input logic [1:0] sel, input logic [31:0] d);
        if (sel == 2'd1) return fwd_m;
        if (sel == 2'd2) return fwd_w;
        return d;
    endfunction

    function automatic logic [31:0] f_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int sh);
        int sa, sb;
        sa = a; sb = b;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return a * 0 + (b << sh);
            4'd9:  return b >> sh;
            4'd10: return sb >>> sh;
            4'd11: return b * 32'd65536;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] f_result();
        logic [31:0] a, bf, b;
        a  = f_fwd(fwd_a_sel, data1_in);
        bf = f_fwd(fwd_b_sel, data2_in);
        b  = alu_src ? imm_in : bf;
        case (md_rd_sel)
            2'd0: return f_alu(alu_ctr, a, b, int'(imm_in[10:6]));
            2'd1: return m_hi;
            2'd2: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    // Spec-level MDU result: plain 64-bit products and integer division.
    task automatic md_compute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sp, sa64, sb64;
        longint unsigned up, ua, ub;
        int sa, sb;
        sa = a; sb = b; sa64 = sa; sb64 = sb; ua = a; ub = b;
        if (op == 3'd1) begin
            sp = sa64 * sb64; {m_phi, m_plo} = sp;
        end else if (op == 3'd2) begin
            up = ua * ub; {m_phi, m_plo} = up;
        end else if (b == 32'd0) begin
            m_plo = 32'hFFFF_FFFF; m_phi = a;
        end else if (op == 3'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m_plo = 32'h8000_0000; m_phi = 32'd0;
        end else if (op == 3'd3) begin
            m_plo = sa / sb; m_phi = sa % sb;
        end else begin
            m_plo = a / b; m_phi = a % b;
        end
    endtask

    task automatic model_reset();
        m_hi = 32'd0; m_lo = 32'd0; m_pend = 1'b0;
    endtask

    // One clock edge: decide acceptance from pre-edge inputs, then advance the model.
    task automatic tick();
        logic [31:0] a, bf;
        bit acc;
        a   = f_fwd(fwd_a_sel, data1_in);
        bf  = f_fwd(fwd_b_sel, data2_in);
        acc = rst && md_start && !m_pend && (md_op >= 3'd1) && (md_op <= 3'd6);
        @(posedge clk);
        edges++;
        if (rst) begin
            if (m_pend && edges == m_done) begin
                m_hi = m_phi; m_lo = m_plo; m_pend = 1'b0;
            end
            if (acc) begin
                if (md_op == 3'd5) m_hi = a;
                else if (md_op == 3'd6) m_lo = a;
                else begin
                    md_compute(md_op, a, bf);
                    m_pend = 1'b1;
                    m_done = edges + ((md_op <= 3'd2) ? 5 : 10);
                end
            end
        end
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_ctr = 4'd0; alu_src = 1'b0; data1_in = 32'd0; data2_in = 32'd0;
        imm_in = 32'd0; fwd_a_sel = 2'd0; fwd_b_sel = 2'd0; fwd_m = 32'd0;
        fwd_w = 32'd0; md_op = 3'd0; md_start = 1'b0; md_rd_sel = 2'd0;
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        md_rd_sel = 2'd1; #1; check({tag, "_hi"}, result_out, ehi);
        md_rd_sel = 2'd2; #1; check({tag, "_lo"}, result_out, elo);
        md_rd_sel = 2'd0;
    endtask

    // Issue one MDU op and count the cycles md_busy stays up after the accept edge.
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, output int busy_cnt);
        data1_in = a; data2_in = b; md_op = op; md_start = 1'b1;
        tick();
        md_start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!md_busy) break;
            busy_cnt++;
            if (inject && i == 2) begin
                md_op = MD_MTLO; data1_in = 32'd9; md_start = 1'b1;
            end else begin
                md_start = 1'b0;
            end
            tick();
        end
        md_start = 1'b0;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("result_out", result_out, f_result());
            check("wdata_out", wdata_out, f_fwd(fwd_b_sel, data2_in));
            check("md_busy", {31'd0, md_busy}, {31'd0, m_pend});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        rst = 1'b0;
        idle_inputs();
        model_reset();
        #3;
        chk_on = 1'b1;
        md_rd_sel = 2'd1; #1;
        check("reset_hi", result_out, 32'd0);
        check("reset_busy", {31'd0, md_busy}, 32'd0);
        md_rd_sel = 2'd0;
        @(negedge clk);
        rst = 1'b1;
        tick();

        fwd_a_sel = 2'd1; fwd_m = 32'd7; data2_in = 32'd5; alu_ctr = ALU_SUB; #1;
        check("sub_fwd", result_out, 32'd2);
        fwd_a_sel = 2'd0; data1_in = 32'hFFFF_FFFF; data2_in = 32'd1; alu_ctr = ALU_SLT; #1;
        check("slt", result_out, 32'd1);
        alu_ctr = ALU_SLTU; #1;
        check("sltu", result_out, 32'd0);
        imm_in = 32'h0000_0080; fwd_b_sel = 2'd2; fwd_w = 32'h8000_0000; alu_ctr = ALU_SRA; #1;
        check("sra", result_out, 32'hE000_0000);
        check("wdata_fwd_w", wdata_out, 32'h8000_0000);
        alu_src = 1'b1; imm_in = 32'h0000_1234; alu_ctr = ALU_LUI; #1;
        check("lui", result_out, 32'h1234_0000);
        idle_inputs();
        tick();

        run_md(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, bc);
        check("mult_busy_cycles", bc, 32'd5);
        read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_md(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, bc);
        read_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

        run_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, bc);
        check("div_busy_cycles", bc, 32'd10);
        read_hilo("div_ignore_mtlo", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md(MD_DIVU, 32'd7, 32'd0, 1'b0, bc);
        read_hilo("divu_by0", 32'd7, 32'hFFFF_FFFF);
        run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, bc);
        read_hilo("div_ovf", 32'd0, 32'h8000_0000);

        md_op = MD_MTHI; data1_in = 32'h55; md_start = 1'b1;
        tick();
        md_start = 1'b0;
        check("mthi_busy", {31'd0, md_busy}, 32'd0);
        read_hilo("mthi", 32'h55, 32'h8000_0000);

        data1_in = 32'd100; data2_in = 32'd7; md_op = MD_DIV; md_start = 1'b1;
        tick();
        md_start = 1'b0;
        repeat (4) tick();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_mid_busy", {31'd0, md_busy}, 32'd0);
        read_hilo("rst_mid", 32'd0, 32'd0);
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b1;
        repeat (15) tick();
        check("after_rst_busy", {31'd0, md_busy}, 32'd0);
        read_hilo("after_rst", 32'd0, 32'd0);

        for (int k = 0; k < 1500; k++) begin
            alu_ctr   = 4'($urandom_range(0, 15));
            alu_src   = 1'($urandom_range(0, 1));
            data1_in  = $urandom;
            data2_in  = $urandom;
            imm_in    = $urandom;
            fwd_m     = $urandom;
            fwd_w     = $urandom;
            fwd_a_sel = 2'($urandom_range(0, 3));
            fwd_b_sel = 2'($urandom_range(0, 3));
            md_rd_sel = 2'($urandom_range(0, 3));
            md_op     = 3'($urandom_range(0, 7));
            md_start  = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0: begin fwd_b_sel = 2'd0; data2_in = 32'd0; end
                1: begin fwd_a_sel = 2'd0; fwd_b_sel = 2'd0;
                         data1_in = 32'h8000_0000; data2_in = 32'hFFFF_FFFF; end
                default: ;
            endcase
            tick();
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
